// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and writeback for a small RV32I subset.
// Outputs decode combinationally from the registered state; illegal opcodes and memory stalls fault.
`timescale 1ns/1ps
module instr_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       mem_ready,
  output logic [2:0] fsm_state,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_fetch,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic       alu_src_imm,
  output logic [3:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       fault
);

  typedef enum logic [2:0] {
    StReset     = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StUnused    = 3'd6,
    StFault     = 3'd7
  } state_e;

  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] OpcLui   = 7'b0110111;

  // Keep at least one bit so a disabled timeout still elaborates.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;

  logic is_op, is_opimm, is_load, is_store, is_lui, legal, timed_out;
  logic [3:0] ex_alu_op;

  always_comb begin
    is_op    = (opcode == OpcOp);
    is_opimm = (opcode == OpcOpImm);
    is_load  = (opcode == OpcLoad);
    is_store = (opcode == OpcStore);
    is_lui   = (opcode == OpcLui);
    // funct7[5] is only meaningful for SUB and SRA among register-register ops.
    legal    = is_opimm | is_load | is_store | is_lui |
               (is_op & ~(funct7_5 & (funct3 != 3'b000) & (funct3 != 3'b101)));
    ex_alu_op = 4'b0000;
    if (is_op) begin
      ex_alu_op = {funct7_5, funct3};
    end else if (is_opimm) begin
      ex_alu_op = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
    end
  end

  assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_q == TimeoutVal) && !mem_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:     state_d = StFetch;
      StFetch: begin
        if (mem_ready)      state_d = StDecode;
        else if (timed_out) state_d = StFault;
      end
      StDecode:    state_d = legal ? StExecute : StFault;
      StExecute:   state_d = (is_load || is_store) ? StMemory : StWriteback;
      StMemory: begin
        if (mem_ready)      state_d = is_store ? StFetch : StWriteback;
        else if (timed_out) state_d = StFault;
      end
      StWriteback: state_d = StFetch;
      StFault:     state_d = StFault;
      default:     state_d = StFault;
    endcase
  end

  // Counter restarts on every state change, so it is zero on entry to FETCH or MEMORY.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_req && !mem_ready && (wait_q != TimeoutVal)) begin
      wait_d = wait_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StReset;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    rf_we        = 1'b0;
    alu_src_imm  = 1'b0;
    alu_op       = 4'b0000;
    wb_sel       = 2'd0;
    fault        = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        ir_we        = mem_ready;
      end
      StExecute: begin
        alu_src_imm = ~is_op;
        alu_op      = ex_alu_op;
      end
      StMemory: begin
        mem_req     = 1'b1;
        mem_we      = is_store;
        alu_src_imm = 1'b1;
        pc_we       = is_store & mem_ready;
      end
      StWriteback: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        wb_sel = is_load ? 2'd1 : (is_lui ? 2'd2 : 2'd0);
      end
      StFault: fault = 1'b1;
      default: ;
    endcase
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset, ALU decode, load/store paths, faults and timeouts.
`timescale 1ns/1ps
module tb_instr_sequencer;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LUI    = 7'b0110111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = OP_IMM;
  logic [2:0] funct3 = 3'b000;
  logic       funct7_5 = 1'b0;
  logic       mem_ready = 1'b1;
  logic [2:0] fsm_state;
  logic       mem_req, mem_we, mem_is_fetch, ir_we, pc_we, rf_we, alu_src_imm, fault;
  logic [3:0] alu_op;
  logic [1:0] wb_sel;
  logic [13:0] outs;

  int checks = 0;
  int errors = 0;

  instr_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .mem_ready(mem_ready), .fsm_state(fsm_state), .mem_req(mem_req), .mem_we(mem_we),
    .mem_is_fetch(mem_is_fetch), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .wb_sel(wb_sel), .fault(fault)
  );

  assign outs = {mem_req, mem_we, mem_is_fetch, ir_we, pc_we, rf_we, alu_src_imm, alu_op,
                 wb_sel, fault};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode   = op;
    funct3   = f3;
    funct7_5 = f7;
  endtask

  // Leaves the DUT in FETCH, one cycle after RESET.
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int exp_seq [5];
    exp_seq = '{1, 2, 3, 5, 1};
    set_instr(OP_IMM, 3'b000, 1'b0);
    mem_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (fsm_state !== 3'd0 || outs !== 14'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: state %0d outs %h, want state 0 outs 0", i, fsm_state,
                 outs);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (fsm_state !== 3'd0 || outs !== 14'd0) begin
      errors++;
      $display("FAIL reset_release: state %0d outs %h, want state 0 outs 0", fsm_state, outs);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (fsm_state !== 3'(exp_seq[i]) || pc_we !== (exp_seq[i] == 5) ||
          rf_we !== (exp_seq[i] == 5)) begin
        errors++;
        $display("FAIL reset_seq[%0d]: state %0d pc_we %b rf_we %b, want state %0d", i,
                 fsm_state, pc_we, rf_we, exp_seq[i]);
      end
    end
  endtask

  // Starts and ends in FETCH; memory always ready.
  task automatic test_alu_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                                input logic f7, input logic [3:0] exp_op, input logic exp_imm,
                                input logic [1:0] exp_wb);
    set_instr(op, f3, f7);
    mem_ready = 1'b1;
    checks++;
    if (fsm_state !== 3'd1 || ir_we !== 1'b1 || mem_is_fetch !== 1'b1) begin
      errors++;
      $display("FAIL %s_fetch: state %0d ir_we %b, want state 1 ir_we 1", name, fsm_state, ir_we);
    end
    step();
    checks++;
    if (fsm_state !== 3'd2 || outs !== 14'd0) begin
      errors++;
      $display("FAIL %s_decode: state %0d outs %h, want state 2 outs 0", name, fsm_state, outs);
    end
    step();
    checks++;
    if (fsm_state !== 3'd3 || alu_op !== exp_op || alu_src_imm !== exp_imm) begin
      errors++;
      $display("FAIL %s_execute: state %0d alu_op %b src_imm %b, want 3 %b %b", name, fsm_state,
               alu_op, alu_src_imm, exp_op, exp_imm);
    end
    step();
    checks++;
    if (fsm_state !== 3'd5 || wb_sel !== exp_wb || rf_we !== 1'b1 || pc_we !== 1'b1) begin
      errors++;
      $display("FAIL %s_wb: state %0d wb_sel %0d rf_we %b pc_we %b, want 5 %0d 1 1", name,
               fsm_state, wb_sel, rf_we, pc_we, exp_wb);
    end
    step();
    checks++;
    if (fsm_state !== 3'd1 || pc_we !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL %s_next: state %0d pc_we %b rf_we %b, want 1 0 0", name, fsm_state, pc_we,
               rf_we);
    end
  endtask

  task automatic test_load_wait();
    int   exp_st [7];
    logic rdy [7];
    exp_st = '{1, 2, 3, 4, 4, 4, 5};
    rdy    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    set_instr(LOAD, 3'b010, 1'b0);
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (fsm_state !== 3'(exp_st[i])) begin
        errors++;
        $display("FAIL load_state[%0d]: got %0d want %0d", i, fsm_state, exp_st[i]);
      end
      if (exp_st[i] == 4) begin
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || alu_op !== 4'b0000 || alu_src_imm !== 1'b1) begin
          errors++;
          $display("FAIL load_mem[%0d]: req %b we %b alu_op %b imm %b, want 1 0 0000 1", i,
                   mem_req, mem_we, alu_op, alu_src_imm);
        end
      end
      if (exp_st[i] == 5) begin
        checks++;
        if (wb_sel !== 2'd1 || rf_we !== 1'b1) begin
          errors++;
          $display("FAIL load_wb: wb_sel %0d rf_we %b, want 1 1", wb_sel, rf_we);
        end
      end
      step();
    end
    mem_ready = 1'b1;
    checks++;
    if (fsm_state !== 3'd1) begin
      errors++;
      $display("FAIL load_next: state %0d want 1", fsm_state);
    end
  endtask

  task automatic test_store();
    logic rf_seen = 1'b0;
    set_instr(STORE, 3'b010, 1'b0);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      rf_seen |= rf_we;
      step();
    end
    rf_seen |= rf_we;
    checks++;
    if (fsm_state !== 3'd4 || mem_we !== 1'b1 || pc_we !== 1'b1 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL store_mem: state %0d we %b pc_we %b req %b, want 4 1 1 1", fsm_state, mem_we,
               pc_we, mem_req);
    end
    step();
    rf_seen |= rf_we;
    checks++;
    if (fsm_state !== 3'd1 || mem_we !== 1'b0 || pc_we !== 1'b0) begin
      errors++;
      $display("FAIL store_next: state %0d we %b pc_we %b, want 1 0 0", fsm_state, mem_we, pc_we);
    end
    checks++;
    if (rf_seen !== 1'b0) begin
      errors++;
      $display("FAIL store_rf_we: saw %b want 0", rf_seen);
    end
  endtask

  task automatic test_illegal(input string name, input logic [6:0] op, input logic [2:0] f3,
                              input logic f7);
    logic strobe_seen = 1'b0;
    set_instr(op, f3, f7);
    mem_ready = 1'b1;
    step();
    checks++;
    if (fsm_state !== 3'd2) begin
      errors++;
      $display("FAIL %s_decode: state %0d want 2", name, fsm_state);
    end
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0];
      step();
      strobe_seen |= pc_we | rf_we | mem_req | ir_we;
      checks++;
      if (fsm_state !== 3'd7 || fault !== 1'b1) begin
        errors++;
        $display("FAIL %s_fault[%0d]: state %0d fault %b, want 7 1", name, i, fsm_state, fault);
      end
    end
    checks++;
    if (strobe_seen !== 1'b0) begin
      errors++;
      $display("FAIL %s_strobes: saw %b want 0", name, strobe_seen);
    end
    reset = 1'b1;
    step();
    checks++;
    if (fsm_state !== 3'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL %s_reset: state %0d fault %b, want 0 0", name, fsm_state, fault);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    set_instr(OP_IMM, 3'b000, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (fsm_state !== 3'd1 || mem_req !== 1'b1) begin
        errors++;
        $display("FAIL timeout_fetch[%0d]: state %0d req %b, want 1 1", i, fsm_state, mem_req);
      end
      step();
    end
    checks++;
    if (fsm_state !== 3'd7 || fault !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fault: state %0d fault %b, want 7 1", fsm_state, fault);
    end
    do_reset();
    // Memory-phase timeout on a load.
    set_instr(LOAD, 3'b000, 1'b0);
    mem_ready = 1'b1;
    step();
    step();
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (fsm_state !== 3'd4) begin
        errors++;
        $display("FAIL timeout_mem[%0d]: state %0d want 4", i, fsm_state);
      end
      step();
    end
    checks++;
    if (fsm_state !== 3'd7 || fault !== 1'b1 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL timeout_mem_fault: state %0d fault %b, want 7 1", fsm_state, fault);
    end
    do_reset();
  endtask

  task automatic test_timeout_rescue();
    set_instr(OP_IMM, 3'b000, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    mem_ready = 1'b1;
    #1;
    checks++;
    if (fsm_state !== 3'd1 || ir_we !== 1'b1) begin
      errors++;
      $display("FAIL rescue_fetch16: state %0d ir_we %b, want 1 1", fsm_state, ir_we);
    end
    step();
    checks++;
    if (fsm_state !== 3'd2 || fault !== 1'b0) begin
      errors++;
      $display("FAIL rescue_decode: state %0d fault %b, want 2 0", fsm_state, fault);
    end
    step();
    step();
    step();
    checks++;
    if (fsm_state !== 3'd1) begin
      errors++;
      $display("FAIL rescue_done: state %0d want 1", fsm_state);
    end
  endtask

  task automatic test_reset_mid();
    set_instr(OP, 3'b000, 1'b0);
    mem_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (fsm_state !== 3'd3) begin
      errors++;
      $display("FAIL midreset_exec: state %0d want 3", fsm_state);
    end
    step();
    checks++;
    if (fsm_state !== 3'd0 || pc_we !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort: state %0d pc_we %b rf_we %b, want 0 0 0", fsm_state, pc_we,
               rf_we);
    end
    reset = 1'b0;
    step();
    checks++;
    if (fsm_state !== 3'd1 || pc_we !== 1'b0) begin
      errors++;
      $display("FAIL midreset_fetch: state %0d pc_we %b, want 1 0", fsm_state, pc_we);
    end
  endtask

  initial begin
    test_reset();
    test_alu_instr("sub",  OP,     3'b000, 1'b1, 4'b1000, 1'b0, 2'd0);
    test_alu_instr("sra",  OP,     3'b101, 1'b1, 4'b1101, 1'b0, 2'd0);
    test_alu_instr("srai", OP_IMM, 3'b101, 1'b1, 4'b1101, 1'b1, 2'd0);
    test_alu_instr("addi", OP_IMM, 3'b000, 1'b1, 4'b0000, 1'b1, 2'd0);
    test_alu_instr("ori",  OP_IMM, 3'b110, 1'b0, 4'b0110, 1'b1, 2'd0);
    test_alu_instr("lui",  LUI,    3'b011, 1'b0, 4'b0000, 1'b1, 2'd2);
    test_load_wait();
    test_store();
    test_illegal("bad_opc", 7'b1111111, 3'b000, 1'b0);
    test_illegal("bad_op_f7", OP, 3'b001, 1'b1);
    test_timeout();
    test_timeout_rescue();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control unit for the CPU core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the strobes and selects for the shared memory port, instruction register, PC, ALU and register file. It sits inside the single-instruction datapath, and its `fsm_state` output is the state the system benches monitor. Unsupported opcodes and stalled memory accesses trap into a sticky fault state.

## Interface
- `TIMEOUT_CYCLES`, default 15: maximum consecutive wait cycles on a memory request. 0 disables the timeout.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7: instruction[6:0] from the instruction register; sampled in DECODE and later states.
- `funct3` in 3: instruction[14:12].
- `funct7_5` in 1: instruction[30].
- `mem_ready` in 1: memory completion; only meaningful while `mem_req`=1.
- `fsm_state` out 3: current state encoding.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write access (store).
- `mem_is_fetch` out 1: request is an instruction fetch (address = PC).
- `ir_we` out 1: load the instruction register.
- `pc_we` out 1: PC <= PC+4.
- `rf_we` out 1: register file write.
- `alu_src_imm` out 1: ALU operand B = immediate (1) or rs2 (0).
- `alu_op` out 4: ALU operation {modifier, funct3}.
- `wb_sel` out 2: writeback source. 0 = ALU, 1 = memory data, 2 = immediate (LUI).
- `fault` out 1: sticky error flag.

## Operation
- State encoding: RESET=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=7. Encoding 6 is unused and goes to FAULT.
- Supported opcodes:
  - OP-IMM 0010011
  - OP 0110011
  - LOAD 0000011
  - STORE 0100011
  - LUI 0110111
- Illegal instructions:
  - any other opcode;
  - OP with `funct7_5`=1 and `funct3` not in {000, 101}.
- State is registered. All outputs are combinational from the state and the inputs.
- **RESET:** all outputs 0. Goes to FETCH unconditionally.
- **FETCH:**
  - Drives `mem_req`=1 and `mem_is_fetch`=1.
  - On `mem_ready`=1: `ir_we`=1 in the same cycle, then goes to DECODE.
  - Otherwise stays in FETCH.
- **DECODE:** illegal instruction goes to FAULT; otherwise goes to EXECUTE. No strobes are driven.
- **EXECUTE:** drives `alu_src_imm` and `alu_op`.
  - OP, OP-IMM and LUI go to WRITEBACK.
  - LOAD and STORE go to MEMORY; the ALU computes rs1+imm.
- **MEMORY:**
  - Drives `mem_req`=1, with `mem_we`=1 for STORE. `alu_op`=0000 and `alu_src_imm`=1 are held so the address stays stable.
  - On `mem_ready`: LOAD goes to WRITEBACK. STORE asserts `pc_we`=1 and goes to FETCH.
- **WRITEBACK:** `rf_we`=1 and `pc_we`=1 for exactly one cycle, then goes to FETCH.
- **FAULT:** `fault`=1 and all strobes 0. Left only by `reset`.
- `alu_src_imm`:
  - 1 for OP-IMM, LOAD, STORE and LUI;
  - 0 for OP.
- `alu_op`:
  - OP: {`funct7_5`, `funct3`}.
  - OP-IMM: {`funct3`==101 ? `funct7_5` : 0, `funct3`}.
  - LOAD, STORE, LUI: 0000.
- `wb_sel`:
  - 1 for LOAD;
  - 2 for LUI;
  - 0 otherwise.
  - Must be valid in WRITEBACK.
- Timeout:
  - The wait counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and is cleared on entry to FETCH or MEMORY.
  - It increments each cycle in which `mem_req`=1 and `mem_ready`=0.
  - When it reaches `TIMEOUT_CYCLES` with `mem_ready` still 0, the next state is FAULT.
  - `mem_ready` takes priority over the timeout in the same cycle.

## Timing
- Reset: on the first rising edge with `reset`=1, the state becomes RESET and all outputs are 0, including `fault`. During that cycle, `mem_req` drops after the edge.
- Reset mid-instruction aborts the instruction at the next edge. No `rf_we` or `pc_we` is issued after that edge.
- After `reset` deasserts: RESET for 1 cycle, then FETCH.
- Cycle counts with zero-wait memory (`mem_ready` held 1):
  - OP, OP-IMM, LUI: 4 cycles (F, D, E, W).
  - STORE: 4 cycles (F, D, E, M).
  - LOAD: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- Single-cycle strobes: `ir_we`, `pc_we` and `rf_we` never stay high for two consecutive cycles.
- `pc_we` fires exactly once per completed instruction. It never fires for an instruction that faults.
- `mem_ready` outside FETCH or MEMORY is ignored.

## Test plan
- **Reset:** `reset`=1 for 2 cycles with `mem_ready`=1.
  - Required: `fsm_state`=0 and all outputs 0.
  - After release, `fsm_state` follows 1, 2, 3, 5, 1 for `opcode`=0010011 / `funct3`=000.
  - `rf_we`=`pc_we`=1 only in state 5.
- **R-type SUB:** `opcode`=0110011, `funct3`=000, `funct7_5`=1.
  - Required in EXECUTE: `alu_op`=1000 and `alu_src_imm`=0.
  - Required in WRITEBACK: `wb_sel`=0.
- **LOAD with 2 wait cycles in MEMORY:**
  - Required: MEMORY lasts 3 cycles with `mem_req`=1 and `mem_we`=0, then WRITEBACK with `wb_sel`=1.
  - Total 7 cycles.
- **STORE, zero wait:**
  - Required: `mem_we`=1 for 1 cycle in MEMORY, `pc_we`=1 in the same cycle, `rf_we` never asserted.
  - Next state is FETCH.
- **Illegal opcode 1111111:**
  - Required: DECODE goes to FAULT (7), `fault`=1, no `pc_we` or `rf_we`.
  - State stays in FAULT for 10+ cycles until `reset`.
- **Timeout:** `TIMEOUT_CYCLES`=15, `mem_ready`=0 in FETCH.
  - Required: FAULT after 16 FETCH cycles.
  - Repeat with `mem_ready`=1 on the 16th FETCH cycle: goes to DECODE, no fault.
